// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch flush, and multi-cycle divider
// sequencing with a watchdog and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 40,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             md_start_ex,
    input  logic             md_done,
    input  logic             branch_taken_ex,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             bubble_mem,
    output logic             md_go,
    output logic             md_busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              MC_W    = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MD_MAX_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    logic [MC_W-1:0]   md_cnt_r;
    logic              timeout_err_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              load_use_s;
    logic              md_last_s;

    // Hazard detection; register x0 never creates a dependency
    always_comb begin
        load_use_s = 1'b0;
        if (mem_read_ex && (rd_ex != 5'd0)) begin
            load_use_s = (rs1_used_id && (rs1_id == rd_ex)) ||
                         (rs2_used_id && (rs2_id == rd_ex));
        end else begin
            load_use_s = 1'b0;
        end
        md_last_s = (md_cnt_r == MC_LAST);
    end

    // Stall/flush decode; the divider owns the pipeline while it is running
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        bubble_mem = 1'b0;
        md_go      = 1'b0;
        md_busy    = 1'b0;
        case (state_r)
            IDLE: begin
                if (md_start_ex) begin
                    md_go      = 1'b1;
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_ex   = 1'b1;
                    bubble_mem = 1'b1;
                end else if (branch_taken_ex) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (load_use_s) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end else begin
                    stall_if = 1'b0;
                end
            end
            MD_WAIT: begin
                md_busy = 1'b1;
                if (md_done || md_last_s) begin
                    stall_if = 1'b0;
                end else begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_ex   = 1'b1;
                    bubble_mem = 1'b1;
                end
            end
            default: begin
                md_busy = 1'b0;
            end
        endcase
    end

    // Divider FSM, watchdog, sticky error and saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            md_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
            stall_cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    md_cnt_r <= '0;
                    if (md_start_ex) begin
                        state_r <= MD_WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        state_r  <= IDLE;
                        md_cnt_r <= '0;
                    end else if (md_last_s) begin
                        state_r       <= IDLE;
                        md_cnt_r      <= '0;
                        timeout_err_r <= 1'b1;
                    end else begin
                        md_cnt_r <= md_cnt_r + MC_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    md_cnt_r <= '0;
                end
            endcase
            if (stall_if && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign timeout_err = timeout_err_r;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl against a cycle-level
// behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int MDMAX = 40;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1_id, rs2_id, rd_ex;
    logic          rs1_used_id, rs2_used_id, mem_read_ex, md_start_ex, md_done, branch_taken_ex;
    logic          stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem;
    logic          md_go, md_busy, timeout_err;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: divider running, cycles already spent waiting, error flag, counter
    bit m_wait;
    int m_cnt;
    bit m_to;
    int m_stalls;

    pipeline_hazard_ctrl #(.MD_MAX_CYCLES(MDMAX), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .md_start_ex(md_start_ex), .md_done(md_done),
        .branch_taken_ex(branch_taken_ex),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex), .bubble_mem(bubble_mem),
        .md_go(md_go), .md_busy(md_busy), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem, md_go, md_busy, timeout_err};
    endfunction

    task automatic model_reset();
        m_wait = 1'b0; m_cnt = 0; m_to = 1'b0; m_stalls = 0;
    endtask

    task automatic idle_inputs();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; mem_read_ex = 1'b0;
        md_start_ex = 1'b0; md_done = 1'b0; branch_taken_ex = 1'b0;
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the model
    task automatic step(input string tag);
        bit sif, sid, sex, fid, fex, bub, go, busy, lu, rel;
        @(negedge clk);
        {sif, sid, sex, fid, fex, bub, go, busy} = '0;
        lu = mem_read_ex && (rd_ex != 0) &&
             ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
        if (!m_wait) begin
            if (md_start_ex)          begin go = 1; sif = 1; sid = 1; sex = 1; bub = 1; end
            else if (branch_taken_ex) begin fid = 1; fex = 1; end
            else if (lu)              begin sif = 1; sid = 1; fex = 1; end
        end else begin
            busy = 1;
            rel  = md_done || (m_cnt == MDMAX - 1);
            if (!rel) begin sif = 1; sid = 1; sex = 1; bub = 1; end
        end
        check({tag, ".ctl"}, {23'd0, dut_vec()}, {23'd0, sif, sid, sex, fid, fex, bub, go, busy, m_to});
        check({tag, ".cnt"}, {24'd0, stall_cnt}, m_stalls);
        @(posedge clk);
        if (sif && m_stalls < CMAX) m_stalls++;
        if (!m_wait) begin
            if (md_start_ex) begin m_wait = 1; m_cnt = 0; end
        end else if (md_done) begin
            m_wait = 0;
        end else if (m_cnt == MDMAX - 1) begin
            m_wait = 0; m_to = 1;
        end else begin
            m_cnt++;
        end
        #1;
    endtask

    initial begin
        int base;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        #2;
        check("rst.ctl", {23'd0, dut_vec()}, 32'd0);
        check("rst.cnt", {24'd0, stall_cnt}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Load-use on rs2
        mem_read_ex = 1; rd_ex = 5'd5; rs2_id = 5'd5; rs2_used_id = 1;
        step("lu");
        idle_inputs();
        step("lu_after");
        check("lu.stall_cnt", {24'd0, stall_cnt}, 32'd1);

        // x0 destination, then an unused matching operand
        mem_read_ex = 1; rd_ex = 5'd0; rs1_id = 5'd0; rs1_used_id = 1;
        step("x0");
        rd_ex = 5'd7; rs1_id = 5'd7; rs1_used_id = 0;
        step("unused");
        check("x0.stall_cnt", {24'd0, stall_cnt}, 32'd1);
        idle_inputs();

        // Divide finishing at cycle 10; hazards during the wait must be ignored
        base = stall_cnt;
        md_start_ex = 1;
        step("div0");
        for (int i = 1; i <= 10; i++) begin
            md_start_ex = 0;
            branch_taken_ex = 1'($urandom_range(0, 1));
            mem_read_ex = 1; rd_ex = 5'd3; rs1_id = 5'd3; rs1_used_id = 1;
            md_done = (i == 10);
            step("div");
        end
        idle_inputs();
        step("div11");
        check("div.busy", {31'd0, md_busy}, 32'd0);
        check("div.stall_cnt", {24'd0, stall_cnt}, base + 10);

        // Branch together with a load-use match: flush wins
        base = stall_cnt;
        branch_taken_ex = 1; mem_read_ex = 1; rd_ex = 5'd9; rs1_id = 5'd9; rs1_used_id = 1;
        step("br_lu");
        idle_inputs();
        step("br_after");
        check("br.stall_cnt", {24'd0, stall_cnt}, base);

        // Watchdog: md_done never arrives
        base = stall_cnt;
        md_start_ex = 1;
        step("wd0");
        md_start_ex = 0;
        for (int i = 1; i <= MDMAX + 3; i++) step("wd");
        check("wd.err", {31'd0, timeout_err}, 32'd1);
        check("wd.stall_cnt", {24'd0, stall_cnt}, base + MDMAX);

        // Random traffic; small register range makes matches common
        for (int i = 0; i < 2500; i++) begin
            rs1_id = 5'($urandom_range(0, 3));
            rs2_id = 5'($urandom_range(0, 3));
            rd_ex  = 5'($urandom_range(0, 3));
            rs1_used_id     = 1'($urandom_range(0, 1));
            rs2_used_id     = 1'($urandom_range(0, 1));
            mem_read_ex     = 1'($urandom_range(0, 1));
            md_start_ex     = ($urandom_range(0, 9) == 0);
            branch_taken_ex = ($urandom_range(0, 7) == 0);
            md_done         = ($urandom_range(0, 11) == 0);
            step("rnd");
        end
        check("rnd.sat", {24'd0, stall_cnt}, CMAX);

        // Reset mid-divide
        idle_inputs();
        md_start_ex = 1;
        step("rdiv0");
        md_start_ex = 0;
        for (int i = 0; i < 5; i++) step("rdiv");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("mrst.ctl", {23'd0, dut_vec()}, 32'd0);
        check("mrst.cnt", {24'd0, stall_cnt}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        mem_read_ex = 1; rd_ex = 5'd2; rs1_id = 5'd2; rs1_used_id = 1;
        step("post_rst");
        idle_inputs();
        step("post_rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
